// File: rtl/steer_en.sv
// Rider detection and steering enable: captures left/right load cells, produces the
// saturated signed load difference, and gates steering with a balance hold-off timer.
module steer_en #(
   parameter bit          fast_sim         = 1'b0,
   parameter logic [11:0] MIN_RIDER_WEIGHT = 12'h200,
   parameter logic [11:0] WT_HYST          = 12'h040
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ld_vld,
   input  logic [11:0] lft_ld,
   input  logic [11:0] rght_ld,
   output logic [11:0] ld_cell_diff,
   output logic        rider_off,
   output logic        en_steer
);

   localparam logic [11:0] GONE_THR = MIN_RIDER_WEIGHT - WT_HYST;

   typedef enum logic [1:0] {IDLE, WAIT, STEER} state_t;

   state_t             state_q;
   logic        [25:0] tmr_q;
   logic        [11:0] lft_q, rght_q;
   logic signed [11:0] diff_sat_q;
   logic               rider_off_q, en_steer_q;

   logic signed [12:0] in_diff_d;
   logic signed [11:0] diff_sat_d;
   logic        [12:0] sum, diff_abs, lop_thr;
   logic signed [12:0] diff;
   logic               rider_on, rider_gone, balanced, lopsided, tmr_full;

   function automatic logic signed [11:0] sat12(input logic signed [12:0] d);
      if (d > 13'sd2047)
         return 12'sh7FF;
      else if (d < -13'sd2048)
         return 12'sh800;
      else
         return d[11:0];
   endfunction

   // The output difference is taken from the incoming sample so it updates on the capture edge.
   always_comb begin
      in_diff_d  = $signed({1'b0, lft_ld}) - $signed({1'b0, rght_ld});
      diff_sat_d = sat12(in_diff_d);
   end

   always_comb begin
      sum        = {1'b0, lft_q} + {1'b0, rght_q};
      diff       = $signed({1'b0, lft_q}) - $signed({1'b0, rght_q});
      diff_abs   = diff[12] ? 13'(-diff) : 13'(diff);
      lop_thr    = sum - (sum >> 4);
      rider_on   = sum > {1'b0, MIN_RIDER_WEIGHT};
      rider_gone = sum < {1'b0, GONE_THR};
      balanced   = diff_abs < (sum >> 2);
      lopsided   = diff_abs > lop_thr;
      tmr_full   = fast_sim ? (tmr_q[14:0] == 15'h7FFF) : (tmr_q == 26'h3FF_FFFF);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lft_q      <= '0;
         rght_q     <= '0;
         diff_sat_q <= '0;
      end else if (ld_vld) begin
         lft_q      <= lft_ld;
         rght_q     <= rght_ld;
         diff_sat_q <= diff_sat_d;
      end
   end

   // Outputs are registered from the next state so they always match the state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         tmr_q       <= '0;
         rider_off_q <= 1'b1;
         en_steer_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               tmr_q <= '0;
               if (rider_on) begin
                  state_q     <= WAIT;
                  rider_off_q <= 1'b0;
               end
            end
            WAIT: begin
               if (rider_gone) begin
                  state_q     <= IDLE;
                  rider_off_q <= 1'b1;
                  tmr_q       <= '0;
               end else if (!balanced) begin
                  tmr_q <= '0;
               end else if (tmr_full) begin
                  state_q    <= STEER;
                  en_steer_q <= 1'b1;
                  tmr_q      <= '0;
               end else begin
                  tmr_q <= tmr_q + 26'd1;
               end
            end
            STEER: begin
               tmr_q <= '0;
               if (rider_gone) begin
                  state_q     <= IDLE;
                  rider_off_q <= 1'b1;
                  en_steer_q  <= 1'b0;
               end else if (lopsided) begin
                  state_q    <= WAIT;
                  en_steer_q <= 1'b0;
               end
            end
            default: begin
               state_q     <= IDLE;
               tmr_q       <= '0;
               rider_off_q <= 1'b1;
               en_steer_q  <= 1'b0;
            end
         endcase
      end
   end

   assign ld_cell_diff = diff_sat_q;
   assign rider_off    = rider_off_q;
   assign en_steer     = en_steer_q;

endmodule

// File: tb/tb_steer_en.sv
// Directed bench for steer_en (fast_sim build): scoreboard for the saturated difference,
// edge-counted checks for the rider/steer state machine.
module tb_steer_en;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ld_vld;
   logic [11:0] lft_ld, rght_ld;
   logic [11:0] ld_cell_diff;
   logic        rider_off, en_steer;

   int          tests = 0;
   int          fails = 0;
   logic [11:0] exp_q[$];

   steer_en #(.fast_sim(1'b1)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ld_vld       (ld_vld),
      .lft_ld       (lft_ld),
      .rght_ld      (rght_ld),
      .ld_cell_diff (ld_cell_diff),
      .rider_off    (rider_off),
      .en_steer     (en_steer)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic edges(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   function automatic logic [11:0] model_sat(input int l, input int r);
      int d;
      d = l - r;
      if (d > 2047) d = 2047;
      if (d < -2048) d = -2048;
      return 12'(d);
   endfunction

   // Drives one strobe at a falling edge; returns at the falling edge after the capture edge.
   task automatic strobe(input string tag, input logic [11:0] l, input logic [11:0] r);
      logic [11:0] exp;
      exp_q.push_back(model_sat(int'(l), int'(r)));
      lft_ld  = l;
      rght_ld = r;
      ld_vld  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ld_vld = 1'b0;
      if (exp_q.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
         exp = exp_q.pop_front();
         chk(tag, {20'd0, ld_cell_diff}, {20'd0, exp});
      end
   endtask

   task automatic wait_steer(output int n);
      n = 0;
      while (n < 40000) begin
         edges(1);
         n++;
         if (en_steer) break;
      end
   endtask

   int n;

   initial begin
      rst_n   = 1'b0;
      ld_vld  = 1'b0;
      lft_ld  = '0;
      rght_ld = '0;
      #12;
      chk("rst_rider_off", {31'd0, rider_off}, 32'd1);
      chk("rst_en_steer",  {31'd0, en_steer},  32'd0);
      chk("rst_diff",      {20'd0, ld_cell_diff}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      edges(2);

      strobe("diff_bal", 12'h200, 12'h200);
      chk("idle_after_capture", {31'd0, rider_off}, 32'd1);
      edges(1);
      chk("wait_rider_off", {31'd0, rider_off}, 32'd0);
      chk("wait_en_steer",  {31'd0, en_steer},  32'd0);

      edges(20000);
      chk("wait_20000_en", {31'd0, en_steer}, 32'd0);
      strobe("diff_unbal", 12'h380, 12'h080);
      edges(1);
      strobe("diff_rebal", 12'h200, 12'h200);
      wait_steer(n);
      chk("holdoff_restart", n, 32'd32768);
      chk("steer_rider_off", {31'd0, rider_off}, 32'd0);

      strobe("diff_lop", 12'h3F8, 12'h008);
      chk("lop_capture_en", {31'd0, en_steer}, 32'd1);
      edges(1);
      chk("lop_en_steer",  {31'd0, en_steer},  32'd0);
      chk("lop_rider_off", {31'd0, rider_off}, 32'd0);

      strobe("diff_rebal2", 12'h200, 12'h200);
      wait_steer(n);
      chk("holdoff_after_lop", n, 32'd32768);

      edges(3);
      rst_n = 1'b0;
      #1;
      chk("async_rst_rider_off", {31'd0, rider_off}, 32'd1);
      chk("async_rst_en_steer",  {31'd0, en_steer},  32'd0);
      chk("async_rst_diff",      {20'd0, ld_cell_diff}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      edges(1);

      strobe("diff_reenter", 12'h200, 12'h200);
      edges(1);
      chk("reenter_wait", {31'd0, rider_off}, 32'd0);
      strobe("diff_hyst_1e0", 12'h0F0, 12'h0F0);
      edges(3);
      chk("hyst_1e0_wait", {31'd0, rider_off}, 32'd0);
      strobe("diff_hyst_1b0", 12'h0D8, 12'h0D8);
      chk("hyst_1b0_capture", {31'd0, rider_off}, 32'd0);
      edges(1);
      chk("hyst_1b0_idle", {31'd0, rider_off}, 32'd1);
      strobe("diff_hyst_1f0", 12'h0F8, 12'h0F8);
      edges(3);
      chk("hyst_1f0_idle", {31'd0, rider_off}, 32'd1);
      chk("hyst_1f0_en",   {31'd0, en_steer},  32'd0);

      strobe("sat_pos", 12'hFFF, 12'h000);
      chk("sat_pos_val", {20'd0, ld_cell_diff}, 32'h7FF);
      strobe("sat_neg", 12'h000, 12'hFFF);
      chk("sat_neg_val", {20'd0, ld_cell_diff}, 32'h800);
      strobe("diff_neg", 12'h100, 12'h180);
      chk("diff_neg_val", {20'd0, ld_cell_diff}, 32'hF80);
      edges(2);
      chk("diff_hold", {20'd0, ld_cell_diff}, 32'hF80);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
